// File: rtl/trng_pkg.sv
// trng_pkg: shared defaults, debias phase type and pointer-width helper
// for the TRNG sample collector.
package trng_pkg;
    localparam int WORD_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {PH_A, PH_B} phase_e;

    function automatic int clog2b(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction
endpackage

// File: rtl/trng_sample_collector_if.sv
// trng_sample_collector_if: valid/ready read port carrying packed entropy words.
interface trng_sample_collector_if #(parameter int WORD_W = 8);
    logic              rd_valid;
    logic              rd_ready;
    logic [WORD_W-1:0] rd_data;

    modport master (output rd_valid, rd_data, input rd_ready);
    modport slave  (input rd_valid, rd_data, output rd_ready);
endinterface

// File: rtl/trng_fifo.sv
// trng_fifo: synchronous first-word fall-through FIFO; pointers carry an
// extra wrap bit so full and empty are distinguished without a counter.
module trng_fifo
    import trng_pkg::*;
#(
    parameter int W     = WORD_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = clog2b(DEPTH);

    logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    always_comb begin
        empty   = wp_q == rp_q;
        full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wp_d    = wp_q + (AW+1)'(do_push);
        rp_d    = rp_q + (AW+1)'(do_pop);
        rdata   = empty ? '0 : mem_q[rp_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/trng_sample_collector.sv
// trng_sample_collector: synchronises the raw entropy bit, samples it on a
// prescaled tick, applies repetition-count health test and optional von Neumann debias, packs words into a FIFO.
module trng_sample_collector
    import trng_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw_bit,
    input  logic debias_en,
    input  logic clr_flags,
    output logic health_fail,
    output logic overflow,
    trng_sample_collector_if.master rd
);
    localparam int PW = clog2b(SAMPLE_DIV);
    localparam int CW = clog2b(WORD_W);
    localparam int RW = clog2b(REP_LIMIT + 1);

    logic [1:0]        sync_q, sync_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              prev_q, prev_d;
    logic [RW-1:0]     rep_q, rep_d, rep_nx;
    phase_e            phase_q, phase_d;
    logic              stored_q, stored_d;
    logic [WORD_W-1:0] word_q, word_d, full_w;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dbe_q, health_q, health_d, ovf_q, ovf_d;
    logic              s, tick, chg, hit, emit, ebit, push, drop, full, empty;

    always_comb begin
        s        = sync_q[1];
        tick     = ena && pre_q == PW'(SAMPLE_DIV - 1);
        chg      = debias_en != dbe_q;
        rep_nx   = (s != prev_q) ? RW'(1) :
                   (rep_q == RW'(REP_LIMIT)) ? rep_q : rep_q + RW'(1);
        // Flag only on the transition into the limit; a stuck source stays saturated.
        hit      = tick && rep_q != RW'(REP_LIMIT) && rep_nx == RW'(REP_LIMIT);
        emit     = tick && (!debias_en || (phase_q == PH_B && stored_q != s));
        ebit     = debias_en ? stored_q : s;
        full_w   = {word_q[WORD_W-2:0], ebit};
        push     = emit && !hit && !chg && cnt_q == CW'(WORD_W - 1);
        sync_d   = {sync_q[0], raw_bit};
        pre_d    = (!ena || tick) ? '0 : pre_q + PW'(1);
        prev_d   = !ena ? 1'b0 : tick ? s : prev_q;
        rep_d    = !ena ? '0 : tick ? rep_nx : rep_q;
        phase_d  = (!ena || chg) ? PH_A :
                   (tick && debias_en) ? ((phase_q == PH_A) ? PH_B : PH_A) : phase_q;
        stored_d = (tick && phase_q == PH_A) ? s : stored_q;
        word_d   = (!ena || hit || chg || push) ? '0 : emit ? full_w : word_q;
        cnt_d    = (!ena || hit || chg || push) ? '0 : emit ? cnt_q + CW'(1) : cnt_q;
        drop     = push && full && !(rd.rd_ready && rd.rd_valid);
        health_d = hit || (health_q && !clr_flags);
        ovf_d    = drop || (ovf_q && !clr_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            pre_q    <= '0;
            prev_q   <= 1'b0;
            rep_q    <= '0;
            phase_q  <= PH_A;
            stored_q <= 1'b0;
            word_q   <= '0;
            cnt_q    <= '0;
            dbe_q    <= 1'b0;
            health_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            pre_q    <= pre_d;
            prev_q   <= prev_d;
            rep_q    <= rep_d;
            phase_q  <= phase_d;
            stored_q <= stored_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            dbe_q    <= debias_en;
            health_q <= health_d;
            ovf_q    <= ovf_d;
        end
    end

    trng_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (full_w),
        .pop   (rd.rd_ready),
        .rdata (rd.rd_data),
        .full  (full),
        .empty (empty)
    );

    assign rd.rd_valid = !empty;
    assign health_fail = health_q;
    assign overflow    = ovf_q;
endmodule
